// File: rtl/seq_adder_sub.sv
// Chunk-serial adder/subtractor: processes CHUNK bits per cycle and
// publishes sum, carry and signed overflow together when the last chunk lands.
module seq_adder_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CW-1:0]    k;

    int               lo;
    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic [CHUNK-1:0] cs;
    logic             cc;
    logic             msb_in;
    logic [WIDTH-1:0] psum_nx;
    logic             last;

    assign ready = (state == IDLE);
    assign last  = (k == CW'(N - 1));

    always_comb begin
        lo      = int'(k) * CHUNK;
        ca      = a_q[lo +: CHUNK];
        cb      = b_q[lo +: CHUNK];
        {cc, cs} = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry};
        // Carry into the top bit recovered from its sum bit: s = a ^ b ^ c.
        msb_in  = ca[CHUNK-1] ^ cb[CHUNK-1] ^ cs[CHUNK-1];
        psum_nx = psum;
        psum_nx[lo +: CHUNK] = cs;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            psum  <= '0;
            carry <= 1'b0;
            k     <= '0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= a;
                        b_q   <= sub ? ~b : b;
                        carry <= sub ? ~cin : cin;
                        psum  <= '0;
                        k     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    psum  <= psum_nx;
                    carry <= cc;
                    if (last) begin
                        sum   <= psum_nx;
                        cout  <= cc;
                        ovf   <= msb_in ^ cc;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        k <= k + CW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_adder_sub.sv
// Bench for seq_adder_sub: three instances (CHUNK 1, 4, 16) share stimulus;
// a per-instance scoreboard checks results and latency on every done pulse.
module tb_seq_adder_sub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;

    logic [2:0]  rdy;
    logic [2:0]  dn;
    logic [2:0]  co;
    logic [2:0]  ov;
    logic [15:0] sm [3];

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          cyc;
    } exp_t;

    exp_t q [3][$];
    int   passes = 0;
    int   total = 0;
    int   cyc = 0;
    bit   stream = 0;
    bit   has_prev [3];
    int   last_acc [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CH = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
        seq_adder_sub #(.WIDTH(16), .CHUNK(CH)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start),
            .a     (a),
            .b     (b),
            .cin   (cin),
            .sub   (sub),
            .ready (rdy[g]),
            .done  (dn[g]),
            .sum   (sm[g]),
            .cout  (co[g]),
            .ovf   (ov[g])
        );
    end

    function automatic int nchunks(int g);
        return (g == 0) ? 16 : ((g == 1) ? 4 : 1);
    endfunction

    function automatic exp_t model(logic [15:0] x, logic [15:0] y,
                                   logic ci, logic sb);
        exp_t        e;
        logic [15:0] ye;
        logic [16:0] r;
        ye  = sb ? ~y : y;
        r   = {1'b0, x} + {1'b0, ye} + {16'd0, sb ? ~ci : ci};
        e.s = r[15:0];
        e.c = r[16];
        e.o = (x[15] == ye[15]) && (r[15] != x[15]);
        e.cyc = 0;
        return e;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        total++;
        assert (obs === expv) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst_n && start) begin
            for (int g = 0; g < 3; g++) begin
                if (rdy[g]) begin
                    exp_t e;
                    if (stream && has_prev[g])
                        check($sformatf("period_d%0d", g),
                              cyc - last_acc[g], nchunks(g) + 2);
                    has_prev[g] = 1;
                    last_acc[g] = cyc;
                    e = model(a, b, cin, sub);
                    e.cyc = cyc;
                    q[g].push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (dn[g]) begin
                check($sformatf("done_pending_d%0d", g), q[g].size() != 0, 1);
                if (q[g].size() != 0) begin
                    exp_t e;
                    e = q[g].pop_front();
                    check($sformatf("sum_d%0d", g), sm[g], e.s);
                    check($sformatf("cout_d%0d", g), co[g], e.c);
                    check($sformatf("ovf_d%0d", g), ov[g], e.o);
                    check($sformatf("lat_d%0d", g), cyc - e.cyc, nchunks(g));
                end
            end
        end
    end

    always @(negedge rst_n) begin
        for (int g = 0; g < 3; g++) q[g].delete();
    end

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (&rdy) begin
                ok = 1;
                break;
            end
        end
        check("idle_timeout", ok, 1);
    endtask

    task automatic op(logic [15:0] x, logic [15:0] y, logic ci, logic sb);
        @(negedge clk);
        a = x; b = y; cin = ci; sub = sb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~x; b = ~y; cin = ~ci; sub = ~sb;
        wait_idle();
    endtask

    task automatic expect_all(string tag, logic [15:0] s, logic c, logic o);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("%s_sum_d%0d", tag, g), sm[g], s);
            check($sformatf("%s_cout_d%0d", tag, g), co[g], c);
            check($sformatf("%s_ovf_d%0d", tag, g), ov[g], o);
        end
    endtask

    initial begin
        #3;
        check("rst_ready", rdy, 3'b111);
        check("rst_done", dn, 3'b000);
        check("rst_sum", sm[1], 16'h0000);
        check("rst_cout", co, 3'b000);
        check("rst_ovf", ov, 3'b000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        expect_all("wrap", 16'h0000, 1'b1, 1'b0);
        op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        expect_all("posovf", 16'h8000, 1'b0, 1'b1);
        op(16'h8000, 16'h0001, 1'b0, 1'b1);
        expect_all("subovf", 16'h7FFF, 1'b1, 1'b1);
        op(16'h0005, 16'h0007, 1'b1, 1'b1);
        expect_all("borrow", 16'hFFFD, 1'b0, 1'b0);
        op(16'h1234, 16'h0FFF, 1'b1, 1'b0);
        expect_all("cin", 16'h2234, 1'b0, 1'b0);

        // Abort mid-RUN: outputs must clear at once and no done may follow.
        @(negedge clk);
        a = 16'h4321; b = 16'h1111; cin = 1'b0; sub = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ready", rdy, 3'b111);
        check("abort_done", dn, 3'b000);
        check("abort_sum", sm[1], 16'h0000);
        check("abort_sum_d0", sm[0], 16'h0000);
        check("abort_cout", co, 3'b000);
        check("abort_ovf", ov, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        op(16'h4321, 16'h1111, 1'b0, 1'b1);
        expect_all("after_rst", 16'h3210, 1'b1, 1'b0);

        // Start held high with operands changing every cycle.
        for (int g = 0; g < 3; g++) has_prev[g] = 0;
        @(negedge clk);
        stream = 1;
        start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        stream = 0;
        wait_idle();

        for (int i = 0; i < 25; i++)
            op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        op(16'h8000, 16'h8000, 1'b0, 1'b0);
        expect_all("negovf", 16'h0000, 1'b1, 1'b1);

        for (int g = 0; g < 3; g++)
            check($sformatf("drained_d%0d", g), q[g].size(), 0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
